piso_serializer: RTL and testbench

Parallel-in/serial-out stage directly upstream of the 1011 sequence detector; it drives the detector's serial `in` bit.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits each word MSB-first, one bit per `ck`.
- A one-word holding register lets back-to-back words stream with no idle gap between them.

---
 rtl/piso_serializer.sv | 104 ++++++++++
 tb/tb_piso_serializer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter feeding the 1011 detector.
// One holding register lets consecutive words stream with no idle gap.
module piso_serializer #(
  parameter  int   WIDTH    = 8,
  parameter  logic IDLE_BIT = 1'b0,
  localparam int   CW       = $clog2(WIDTH)
) (
  input  logic             ck,
  input  logic             rs,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;

  state_t           w_state;
  logic [WIDTH-1:0] w_sreg;
  logic [WIDTH-1:0] w_hold;
  logic             w_hold_full;
  logic [CW-1:0]    w_cnt;
  logic             w_xfer;

  // ready comes from registers only; no path from din_valid
  assign din_ready  = !r_hold_full;
  assign w_xfer     = din_valid && din_ready;
  assign sout_valid = (r_state == S_SHIFT);
  assign sout       = sout_valid ? r_sreg[WIDTH-1] : IDLE_BIT;
  assign busy       = sout_valid || r_hold_full;
  assign bit_cnt    = r_cnt;

  always_ff @(posedge ck or posedge rs) begin
    if (rs) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_sreg      <= w_sreg;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_cnt       <= w_cnt;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_sreg      = r_sreg;
    w_hold      = r_hold;
    w_hold_full = r_hold_full;
    w_cnt       = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_sreg  = din;
          w_cnt   = LAST;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_sreg = {r_sreg[WIDTH-2:0], 1'b0};
          w_cnt  = r_cnt - 1'b1;
          if (w_xfer) begin
            w_hold      = din;
            w_hold_full = 1'b1;
          end
        end else if (r_hold_full) begin
          w_sreg      = r_hold;
          w_hold_full = 1'b0;
          w_cnt       = LAST;
        end else if (w_xfer) begin
          // last bit going out: new word bypasses hold
          w_sreg = din;
          w_cnt  = LAST;
        end else begin
          w_sreg  = '0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed cases plus random traffic,
// checked against a bit-queue model of the serial stream.
module tb_piso_serializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          ck = 1'b0;
  logic          rs = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready, sout, sout_valid, busy;
  logic [CW-1:0] bit_cnt;
  logic          din_ready1, sout1, sout_valid1, busy1;
  logic [CW-1:0] bit_cnt1;

  piso_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) u_dut0 (
    .ck(ck), .rs(rs), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
    .busy(busy), .bit_cnt(bit_cnt)
  );

  piso_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) u_dut1 (
    .ck(ck), .rs(rs), .din(din), .din_valid(din_valid),
    .din_ready(din_ready1), .sout(sout1), .sout_valid(sout_valid1),
    .busy(busy1), .bit_cnt(bit_cnt1)
  );

  always #5 ck = ~ck;

  int   errs = 0;
  int   checks = 0;
  logic q[$];
  logic exp_ready = 1'b1;
  int   accepted = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending bits in q fully describe the block: words in flight are
  // ceil(bits/W); two words means the holding register is occupied.
  task automatic check_outputs();
    logic     v;
    logic     b;
    int       n;
    n = q.size();
    v = (n != 0);
    b = v ? q[0] : 1'b0;
    exp_ready = ((n + W - 1) / W) < 2;
    chk("sout_valid", 32'(sout_valid), 32'(v));
    chk("sout", 32'(sout), 32'(v ? b : 1'b0));
    chk("busy", 32'(busy), 32'(v));
    chk("din_ready", 32'(din_ready), 32'(exp_ready));
    chk("bit_cnt", 32'(bit_cnt), v ? 32'((n - 1) % W) : 32'd0);
    chk("sout_valid_i1", 32'(sout_valid1), 32'(v));
    chk("sout_i1", 32'(sout1), 32'(v ? b : 1'b1));
    chk("din_ready_i1", 32'(din_ready1), 32'(exp_ready));
    if (v) void'(q.pop_front());
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d);
    @(negedge ck);
    check_outputs();
    din_valid = v;
    din       = d;
    if (v && exp_ready) begin
      accepted++;
      for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom));
  endtask

  task automatic pulse_reset();
    @(negedge ck);
    rs = 1'b1;
    din_valid = 1'b0;
    #1;
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_sout_i1", 32'(sout1), 32'd1);
    chk("rst_sout_valid", 32'(sout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    q.delete();
    exp_ready = 1'b1;
    @(negedge ck);
    rs = 1'b0;
  endtask

  initial begin
    int cyc;
    pulse_reset();

    // single word, then drain and idle
    cycle(1'b1, 8'hB0);
    idle(W + 3);

    // back-to-back words with valid held high
    cycle(1'b1, 8'hB0);
    for (int i = 0; i < W; i++) cycle(1'b1, 8'hB0);
    idle(2 * W + 2);

    // transfer lands exactly on the last-bit edge: bypass
    cycle(1'b1, 8'hC3);
    idle(W - 1);
    cycle(1'b1, 8'h00);
    idle(W + 2);

    // reset while shifting with hold occupied
    cycle(1'b1, 8'hFF);
    cycle(1'b1, 8'hA5);
    idle(3);
    pulse_reset();
    cycle(1'b1, 8'h5A);
    idle(W + 2);

    // random traffic
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      cycle(($urandom_range(0, 9) < 7), W'($urandom));
      cyc++;
    end
    chk("random_accept_done", 32'(accepted >= 1000), 32'd1);
    idle(2 * W + 2);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
